// File: rtl/mcs6530_timer.sv
// MCS6530-style interval timer: 8-bit down-counter behind a 1/8/64/1024
// prescaler. After an underflow it drops to one decrement per clock and
// raises a flag that can drive an active-low interrupt.
module mcs6530_timer (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       sel,
    input  logic       we_n,
    input  logic [3:0] A,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       OE,
    output logic       IRQ,
    output logic       IRQ_EN
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PRE_W = 10;
    localparam int unsigned DIV_W = 2;

    logic [CNT_W-1:0] counter_q, counter_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic             fast_q, fast_d;
    logic             flag_q, flag_d;
    logic             irq_en_q, irq_en_d;

    logic             wr_c;
    logic             tread_c;
    logic             pre_wrap_c;
    logic             tick_c;
    logic [PRE_W-1:0] pre_max_c;

    // A[2] is decoded upstream (RS0/A2) and has no meaning inside the timer.
    logic             unused_a2;
    assign unused_a2 = A[2];

    // Access decode: one write or one timer read per cycle while sel is held.
    assign wr_c    = sel & ~we_n;
    assign tread_c = sel & we_n & ~A[0];

    // Terminal prescale count (N-1) for the selected divider.
    always_comb begin
        pre_max_c = PRE_W'(1023);
        case (div_q)
            2'b00:   pre_max_c = PRE_W'(0);
            2'b01:   pre_max_c = PRE_W'(7);
            2'b10:   pre_max_c = PRE_W'(63);
            default: pre_max_c = PRE_W'(1023);
        endcase
    end

    assign pre_wrap_c = (prescale_q == pre_max_c);
    assign tick_c     = ~wr_c & (fast_q | pre_wrap_c);

    // Next-state: a write overrides everything; an underflow beats a read's flag clear.
    always_comb begin
        counter_d  = counter_q;
        div_d      = div_q;
        prescale_d = prescale_q;
        fast_d     = fast_q;
        flag_d     = flag_q;
        irq_en_d   = irq_en_q;

        if (wr_c) begin
            counter_d  = DI;
            div_d      = A[1:0];
            prescale_d = '0;
            fast_d     = 1'b0;
            flag_d     = 1'b0;
            irq_en_d   = A[3];
        end else begin
            prescale_d = pre_wrap_c ? '0 : prescale_q + PRE_W'(1);

            if (tread_c) begin
                irq_en_d = A[3];
                flag_d   = 1'b0;
            end

            if (tick_c) begin
                counter_d = counter_q - CNT_W'(1);
                if (counter_q == '0) begin
                    flag_d = 1'b1;
                    fast_d = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous reset to the free-running /1024 state.
    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            counter_q  <= '1;
            div_q      <= 2'b11;
            prescale_q <= '0;
            fast_q     <= 1'b0;
            flag_q     <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            div_q      <= div_d;
            prescale_q <= prescale_d;
            fast_q     <= fast_d;
            flag_q     <= flag_d;
            irq_en_q   <= irq_en_d;
        end
    end

    // Read mux and interrupt outputs; DO is forced quiet while in reset.
    assign OE     = sel & we_n;
    assign DO     = (OE & rst_n) ? (A[0] ? {flag_q, 7'b0} : counter_q) : 8'h00;
    assign IRQ    = ~(flag_q & irq_en_q);
    assign IRQ_EN = irq_en_q;

endmodule

// File: tb/tb_mcs6530_timer.sv
// Bench for mcs6530_timer: directed scenarios followed by random traffic,
// all checked against an elapsed-time model of the counter.
module tb_mcs6530_timer;

    logic       phi2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       we_n = 1'b1;
    logic [3:0] A = 4'h0;
    logic [7:0] DI = 8'h00;
    logic [7:0] DO;
    logic       OE;
    logic       IRQ;
    logic       IRQ_EN;

    int vectors = 0;
    int miscompares = 0;

    // Model: last loaded value, divider, clocks since the load, flag, enable.
    int m_v;
    int m_n;
    int m_t;
    bit m_flag;
    bit m_ien;

    mcs6530_timer dut (
        .phi2   (phi2),
        .rst_n  (rst_n),
        .sel    (sel),
        .we_n   (we_n),
        .A      (A),
        .DI     (DI),
        .DO     (DO),
        .OE     (OE),
        .IRQ    (IRQ),
        .IRQ_EN (IRQ_EN)
    );

    always #5 phi2 = ~phi2;

    function automatic int div_of(input logic [1:0] d);
        case (d)
            2'b00:   return 1;
            2'b01:   return 8;
            2'b10:   return 64;
            default: return 1024;
        endcase
    endfunction

    // The counter spends N clocks on each value down to zero, then one clock each.
    function automatic logic [7:0] m_cnt();
        int l;
        l = (m_v + 1) * m_n;
        if (m_t < l) return 8'(m_v - m_t / m_n);
        return 8'(255 - ((m_t - l) % 256));
    endfunction

    function automatic bit m_uf_next();
        int l;
        int t1;
        l  = (m_v + 1) * m_n;
        t1 = m_t + 1;
        return (t1 >= l) && (((t1 - l) % 256) == 0);
    endfunction

    task automatic model_reset();
        m_v = 255; m_n = 1024; m_t = 0; m_flag = 1'b0; m_ien = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic w, input logic [3:0] a, input logic [7:0] d);
        bit uf;
        if (s && !w) begin
            m_v = int'(d); m_n = div_of(a[1:0]); m_t = 0;
            m_flag = 1'b0; m_ien = a[3];
        end else begin
            uf = m_uf_next();
            m_t = m_t + 1;
            if (s && w && !a[0]) begin
                m_ien = a[3];
                m_flag = 1'b0;
            end
            if (uf) m_flag = 1'b1;
        end
    endtask

    function automatic logic [7:0] exp_do();
        if (!rst_n) return 8'h00;
        if (sel && we_n) return A[0] ? {m_flag, 7'b0} : m_cnt();
        return 8'h00;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".DO"},     DO,            exp_do());
        check({tag, ".OE"},     {7'b0, OE},    {7'b0, sel & we_n});
        check({tag, ".IRQ"},    {7'b0, IRQ},   {7'b0, ~(m_flag & m_ien)});
        check({tag, ".IRQ_EN"}, {7'b0, IRQ_EN}, {7'b0, m_ien});
    endtask

    // One clock: drive, check before the edge, advance the model on the edge.
    task automatic cyc(input string tag, input logic s, input logic w, input logic [3:0] a, input logic [7:0] d);
        sel = s; we_n = w; A = a; DI = d;
        #3;
        check_outputs(tag);
        @(posedge phi2);
        model_edge(s, w, a, d);
        #1;
    endtask

    task automatic wr(input string tag, input logic [3:0] a, input logic [7:0] d);
        cyc(tag, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd_timer(input string tag, input logic [3:0] a);
        cyc(tag, 1'b1, 1'b1, {a[3:1], 1'b0}, 8'h00);
    endtask

    task automatic rd_status(input string tag);
        cyc(tag, 1'b1, 1'b1, 4'b0001, 8'h00);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, 1'b1, 4'h0, 8'h00);
    endtask

    // Asynchronous reset pulse in the middle of a cycle, checked before any edge.
    task automatic mid_reset(input string tag);
        sel = 1'b1; we_n = 1'b1; A = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_IRQ"},    {7'b0, IRQ},    8'h01);
        check({tag, ".rst_IRQ_EN"}, {7'b0, IRQ_EN}, 8'h00);
        check({tag, ".rst_DO"},     DO,             8'h00);
        @(posedge phi2);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        int n_rst;
        model_reset();
        @(posedge phi2);
        #1;
        check("por.IRQ",    {7'b0, IRQ},    8'h01);
        check("por.IRQ_EN", {7'b0, IRQ_EN}, 8'h00);
        check("por.DO",     DO,             8'h00);
        rst_n = 1'b1;

        // Free-running from 0xFF at /1024 after reset.
        for (int i = 0; i < 2100; i++) rd_timer("por_run", 4'b0000);

        // 1T: 03,02,01,00 then FF with flag set, interrupt disabled.
        wr("t1_wr", 4'b0100, 8'h03);
        for (int i = 0; i < 4; i++) rd_timer("t1_rd", 4'b0000);
        rd_status("t1_st");
        idle("t1_idle");

        // 8T with IRQ enabled, then a clearing read with A=0000.
        wr("t8_wr", 4'b1101, 8'h02);
        for (int i = 0; i < 24; i++) rd_timer("t8_rd", 4'b1000);
        rd_status("t8_st25");
        rd_timer("clr_rd", 4'b0000);
        rd_status("clr_st");
        for (int i = 0; i < 4; i++) rd_timer("clr_run", 4'b0000);

        // Repeated status reads leave the flag and IRQ alone.
        wr("st_wr", 4'b1000, 8'h01);
        idle("st_idle");
        idle("st_idle");
        for (int i = 0; i < 3; i++) rd_status("st_rep");

        // Write lands on the underflow cycle: write wins, slow rate restored.
        wr("col_wr0", 4'b0000, 8'h00);
        wr("col_wr1", 4'b0001, 8'h10);
        rd_status("col_st");
        for (int i = 0; i < 10; i++) rd_timer("col_rd", 4'b0000);

        // A held write reloads each cycle so the counter never moves.
        for (int i = 0; i < 5; i++) wr("hold_wr", 4'b0100, 8'h42);
        rd_timer("hold_rd", 4'b0000);
        rd_timer("hold_rd", 4'b0000);

        // 64T underflow with IRQ asserted, then reset mid-count.
        wr("r64_wr", 4'b1010, 8'h00);
        for (int i = 0; i < 66; i++) idle("r64_idle");
        mid_reset("r64");
        rd_timer("r64_post", 4'b0000);
        rd_status("r64_post_st");

        // Random traffic with small load values so underflows are frequent.
        n_rst = 0;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r < 8)
                wr("rnd_wr", 4'($urandom_range(0, 15)) & 4'b1011, 8'($urandom_range(0, 20)));
            else if (r < 10)
                wr("rnd_wrb", 4'($urandom_range(0, 15)), 8'($urandom));
            else if (r < 80)
                rd_timer("rnd_rt", 4'($urandom_range(0, 15)));
            else if (r < 110)
                rd_status("rnd_st");
            else if (r == 199 && n_rst < 4) begin
                mid_reset("rnd_rst");
                n_rst++;
            end else
                cyc("rnd_idle", 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
